bin2bcd_seq: RTL

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It is the parametrised successor of the combinational plus-three cell. The input width and output digit count are generic. One iteration runs per clock, and a start/busy/done handshake frames each conversion. The block sits between binary arithmetic results and the seven-segment or display drivers.

---
 rtl/bin2bcd_if.sv | 21 ++
 rtl/bin2bcd_seq.sv | 101 ++++++++++
 2 files changed

// File: rtl/bin2bcd_if.sv
// Start/busy/done handshake and result bus for the sequential binary-to-BCD converter.
//   start  : request a conversion (master -> slave)
//   bin    : binary operand, sampled with an accepted start (master -> slave)
//   busy   : iterations in progress (slave -> master)
//   done   : one-cycle pulse, bcd/ovf hold a fresh result (slave -> master)
//   bcd    : packed BCD result, digit 0 at [3:0] (slave -> master)
//   ovf    : value needed more than DIGITS digits (slave -> master)
interface bin2bcd_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);
   logic                start;
   logic [BIN_W-1:0]    bin;
   logic                busy;
   logic                done;
   logic [4*DIGITS-1:0] bcd;
   logic                ovf;

   modport master (output start, output bin, input busy, input done, input bcd, input ovf);
   modport slave  (input start, input bin, output busy, output done, output bcd, output ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per clock.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : bin2bcd_if slave (start/bin in, busy/done/bcd/ovf out)
// A conversion takes BIN_W iterations; done pulses the cycle after the last one.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | running iterations, busy=1
// DONE  | one cycle, done=1; a start here is accepted back-to-back
module bin2bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   bin2bcd_if.slave    bus
);
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int SCR_W = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state;
   logic [BIN_W-1:0]   shreg;
   logic [SCR_W-1:0]   scratch;
   logic               sticky;
   logic [CNT_W-1:0]   cnt;
   logic               busy_q;
   logic               done_q;
   logic [SCR_W-1:0]   bcd_q;
   logic               ovf_q;

   logic [SCR_W-1:0]   adj;
   logic [SCR_W-1:0]   scr_next;
   logic               shift_out;

   // Plus-three on every digit in parallel, then one left shift of {scratch, shreg}.
   always_comb begin
      adj = scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[4*d +: 4] >= 4'd5)
            adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
      scr_next  = {adj[SCR_W-2:0], shreg[BIN_W-1]};
      shift_out = adj[SCR_W-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         scratch <= '0;
         sticky  <= 1'b0;
         cnt     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  shreg   <= bus.bin;
                  scratch <= '0;
                  sticky  <= 1'b0;
                  cnt     <= CNT_W'(BIN_W);
                  busy_q  <= 1'b1;
                  state   <= SHIFT;
               end else begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            SHIFT: begin
               scratch <= scr_next;
               shreg   <= shreg << 1;
               sticky  <= sticky | shift_out;
               cnt     <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  bcd_q  <= scr_next;
                  ovf_q  <= sticky | shift_out;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= DONE;
               end
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.bcd  = bcd_q;
   assign bus.ovf  = ovf_q;
endmodule
